// File: rtl/ysyx_25040111_icache_axi.sv
// I-cache refill master: one AXI4 INCR read burst per missed line.
// Each accepted beat comes back to the cache as a registered one-cycle strobe.
module ysyx_25040111_icache_axi #(
    parameter int         LINE_WORDS = 1,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rstart,
    output logic        rok,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic        rerr,
    output logic        busy,
    output logic        io_arvalid,
    input  logic        io_arready,
    output logic [31:0] io_araddr,
    output logic [3:0]  io_arid,
    output logic [7:0]  io_arlen,
    output logic [2:0]  io_arsize,
    output logic [1:0]  io_arburst,
    input  logic        io_rvalid,
    output logic        io_rready,
    input  logic [31:0] io_rdata,
    input  logic [1:0]  io_rresp,
    input  logic        io_rlast,
    input  logic [3:0]  io_rid
);

    localparam int            CW   = $clog2(LINE_WORDS) + 1;
    localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
    localparam logic [31:0]   MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          err;
    logic          beat;
    logic          at_last;
    logic          done;
    logic          bad;

    assign beat    = (state == R) && io_rvalid;
    assign at_last = (cnt == LAST);
    // A burst ends on the slave's rlast or our own count, whichever is first.
    assign done    = beat && (io_rlast || at_last);
    assign bad     = (io_rresp != 2'b00) || (io_rid != AXI_ID) ||
                     (io_rlast != at_last);

    assign io_arvalid = (state == AR);
    assign io_rready  = (state == R);
    assign busy       = (state != IDLE);
    assign io_arid    = AXI_ID;
    assign io_arlen   = 8'(LINE_WORDS - 1);
    assign io_arsize  = 3'b010;
    assign io_arburst = 2'b01;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (rstart) state_n = AR;
            AR:      if (io_arready) state_n = R;
            R:       if (done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_araddr <= 32'd0;
            cnt       <= '0;
            err       <= 1'b0;
            rok       <= 1'b0;
            rdata     <= 32'd0;
            rlast     <= 1'b0;
            rerr      <= 1'b0;
        end else begin
            rok   <= beat;
            rlast <= done;
            rerr  <= done && (err || bad);
            if (state == IDLE && rstart) begin
                io_araddr <= addr & MASK;
                cnt       <= '0;
                err       <= 1'b0;
            end
            if (beat) begin
                rdata <= io_rdata;
                cnt   <= cnt + CW'(1);
                err   <= err || bad;
            end
        end
    end

endmodule

// File: doc/ysyx_25040111_icache_axi.md
# ysyx_25040111_icache_axi

Miss-refill read master that sits directly downstream of the instruction cache. On a one-cycle refill request carrying the miss address, it issues one AXI4 INCR read burst for the whole cache line and returns each beat to the cache as a registered one-cycle data strobe. It flags bad responses and protocol mismatches on the final beat.

## Interface
Parameters:
- LINE_WORDS, default 1: 32-bit words per cache line; legal values 1, 2, 4, 8, 16.
- AXI_ID, default 4'd0: constant value driven on arid and expected back on rid.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- addr  in  32  miss address from the cache; sampled only with rstart.
- rstart  in  1  one-cycle refill request pulse.
- rok  out  1  one-cycle strobe; rdata is valid this cycle.
- rdata  out  32  refill word, in incrementing address order.
- rlast  out  1  high with rok on the final word of the line.
- rerr  out  1  high with the final rok if any error occurred in this burst.
- busy  out  1  high from the cycle after an accepted rstart until the final rok cycle (exclusive).
- io_arvalid  out  1, io_arready  in  1, io_araddr  out  32, io_arid  out  4, io_arlen  out  8, io_arsize  out  3, io_arburst  out  2: AXI4 read-address channel.
- io_rvalid  in  1, io_rready  out  1, io_rdata  in  32, io_rresp  in  2, io_rlast  in  1, io_rid  in  4: AXI4 read-data channel.

## Operation
- States: IDLE, AR, R.
- IDLE:
  - On rstart, latch araddr = addr with the low log2(LINE_WORDS*4) bits cleared.
  - Clear the beat counter and the error flag, then go to AR.
  - rstart in AR or R is ignored; the cache never issues one while busy.
- AR:
  - io_arvalid = 1, with io_araddr, io_arid, io_arlen, io_arsize and io_arburst stable.
  - Hold until io_arready; on the handshake go to R.
- Address-channel constants:
  - io_arid = AXI_ID.
  - io_arlen = LINE_WORDS-1.
  - io_arsize = 3'b010.
  - io_arburst = 2'b01 (INCR).
  - These are driven even outside AR.
- R:
  - io_rready = 1.
  - Each io_rvalid & io_rready beat registers io_rdata into rdata, pulses rok next cycle and increments the beat counter (width log2(LINE_WORDS)+1).
- Error flag (sticky for the burst), set by any of:
  - io_rresp != 2'b00.
  - io_rid != AXI_ID.
  - io_rlast high on a beat other than beat LINE_WORDS-1.
  - io_rlast low on beat LINE_WORDS-1.
- Burst termination:
  - The burst ends on the first beat with io_rlast or counter == LINE_WORDS-1, whichever comes first.
  - That beat's rok carries rlast = 1 and rerr = error flag, including any error from that beat itself.
  - The state returns to IDLE.
- Data after termination: beats arriving after termination (slave over-length) are not accepted, because io_rready is low in IDLE.
- The cache is responsible for discarding data when rerr = 1; this block never retries.

## Timing
- Reset values: rok=0, rdata=0, rlast=0, rerr=0, busy=0, io_arvalid=0, io_rready=0, io_araddr=0, state IDLE, counter 0. Reset takes effect immediately, independent of clock.
- Reset mid-burst: outputs drop asynchronously; the outstanding transaction is abandoned (the slave is reset by the same signal).
- rstart at cycle 0 gives io_arvalid=1 and busy=1 from cycle 1.
- io_arready at cycle n gives io_arvalid=0 and io_rready=1 from cycle n+1.
- Beat accepted at cycle k gives rok=1 with rdata at cycle k+1. rok is never high two cycles in a row unless beats were accepted on consecutive cycles.
- Final beat at cycle k: rok, rlast and rerr are valid at k+1, with busy=0 and state IDLE at k+1. A new rstart at k+1 is accepted.
- Minimum latency with zero-wait slave: rstart at 0 to first rok at 3.
- rok, rlast and rerr are low in every cycle that carries no beat.

## Test plan
- LINE_WORDS=1, zero-wait slave; rstart with addr=0x8000_0013:
  - io_araddr=0x8000_0010, io_arlen=0 and io_arvalid at cycle 1.
  - Beat 0xDEADBEEF returns rok=1, rdata=0xDEADBEEF, rlast=1, rerr=0 at cycle 3.
- LINE_WORDS=4, slave with arready delayed 3 cycles and rvalid gaps; addr=0x3000_001C:
  - io_araddr=0x3000_0010, io_arlen=3, arvalid held stable until arready.
  - Four roks in order 0x11,0x22,0x33,0x44; rlast only on 0x44.
- LINE_WORDS=4, rresp=2'b10 on beat 1: all four roks delivered, rerr=1 only on the fourth.
- LINE_WORDS=4, slave asserts rlast on beat 2: burst ends with rok, rlast=1, rerr=1 on beat 2, busy=0 and io_rready=0 next cycle.
- Reset asserted asynchronously mid-R:
  - io_rready and busy drop before the next clock edge.
  - After release, a fresh rstart completes normally with rerr=0.
- Back-to-back: rstart in the same cycle as the final rok is accepted, and io_arvalid rises the following cycle.
